// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x oversampling UART receiver with one-entry valid/ready holding register
// Optional parity stage compiled in with UART_RX_PARITY_EN.
module uart_rx #(
  parameter int DBIT       = 8,
  parameter int OVS        = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] rx_data,
  output logic            rx_valid,
  input  logic            rx_ready,
  output logic            frame_err,
  output logic            parity_err,
  output logic            overrun
);

  localparam int CW = $clog2(OVS);
  localparam int BW = $clog2(DBIT + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic       ODD      = (PARITY_ODD != 0);
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  logic            rx_meta_q, rx_s_q;
  logic [2:0]      state_q, state_d;
  logic [CW-1:0]   tick_q, tick_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [DBIT-1:0] sh_q, sh_d;
  logic [DBIT-1:0] data_q, data_d;
  logic            valid_q, valid_d;
  logic            fe_q, fe_d;
  logic            ovr_q, ovr_d;
  logic            byte_done;
  logic            mid_bit, end_bit;
`ifdef UART_RX_PARITY_EN
  logic            par_q, par_d;
  logic            pe_q, pe_d;
`else
  logic            unused_cfg;
  assign unused_cfg = ^PARITY_ODD;
`endif

  assign mid_bit = (tick_q == CW'(OVS/2 - 1));
  assign end_bit = (tick_q == CW'(OVS - 1));

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    byte_done = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d     = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          tick_d  = '0;
          bit_d   = '0;
        end
      end
      S_START: begin
        if (s_tick) begin
          if (mid_bit) begin
            tick_d  = '0;
            state_d = rx_s_q ? S_IDLE : S_DATA;
          end else begin
            tick_d = tick_q + CW'(1);
          end
        end
      end
      S_DATA: begin
        if (s_tick) begin
          if (end_bit) begin
            sh_d   = {rx_s_q, sh_q[DBIT-1:1]};
            tick_d = '0;
            bit_d  = bit_q + BW'(1);
            if (bit_q == BW'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end
          end else begin
            tick_d = tick_q + CW'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (s_tick) begin
          if (end_bit) begin
            par_d   = rx_s_q;
            tick_d  = '0;
            state_d = S_STOP;
          end else begin
            tick_d = tick_q + CW'(1);
          end
        end
      end
`endif
      S_STOP: begin
        if (s_tick) begin
          if (end_bit) begin
            // Returning to IDLE at mid stop bit lets a back-to-back start edge be caught.
            byte_done = 1'b1;
            state_d   = S_IDLE;
          end else begin
            tick_d = tick_q + CW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    fe_d    = fe_q;
    ovr_d   = ovr_q;
`ifdef UART_RX_PARITY_EN
    pe_d    = pe_q;
`endif
    if (byte_done) begin
      if (!valid_q || rx_ready) begin
        data_d  = sh_q;
        fe_d    = ~rx_s_q;
        valid_d = 1'b1;
        ovr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        pe_d    = ((^sh_q) ^ par_q) != ODD;
`endif
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && rx_ready) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= S_IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q     <= 1'b0;
      pe_q      <= 1'b0;
`endif
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      fe_q      <= fe_d;
      ovr_q     <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_q     <= par_d;
      pe_q      <= pe_d;
`endif
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = fe_q;
  assign overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = pe_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx.md
# uart_rx

Oversampling UART receiver that consumes the 16x baud tick from the baud-rate generator and turns the asynchronous serial line into parallel bytes. It returns each byte on a valid/ready handshake with a one-entry holding register. It flags framing, parity and overrun errors, and sits between the pad-side RX pin and the host or FIFO logic.

## Interface
- DBIT, 8: data bits per frame, LSB first.
- OVS, 16: s_tick pulses per bit period. Must be even and at least 4.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd. Used only when parity is compiled in.
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- s_tick  in  1  oversample strobe, one clk wide, at OVS times the baud rate.
- rx  in  1  serial input, asynchronous to clk, idles high.
- rx_data  out  DBIT  received byte, stable while rx_valid is high.
- rx_valid  out  1  byte available in the holding register.
- rx_ready  in  1  consumer accepts; a transfer happens when rx_valid and rx_ready are both high.
- frame_err  out  1  stop bit of the held byte was sampled low; qualified by rx_valid.
- parity_err  out  1  parity mismatch on the held byte; qualified by rx_valid.
- overrun  out  1  sticky; a completed byte was dropped because the holding register was full.

## Operation
- rx passes through a 2-flop synchronizer. Both flops reset to 1. All decisions below use the synchronized value, rx_s.
- State machine states: IDLE, START, DATA, PARITY, STOP. Reset state is IDLE.
- Tick counter width is clog2(OVS). It advances only on cycles where s_tick is high.
- IDLE: when rx_s is 0, go to START and clear the tick counter. This transition does not wait for s_tick.
- START: on the tick where the counter equals OVS/2-1 (mid start bit):
  - rx_s = 1: false start, return to IDLE.
  - rx_s = 0: clear the counter and go to DATA.
- DATA: on the tick where the counter equals OVS-1 (bit centre):
  - Shift rx_s into the MSB of the shift register (LSB-first frame), clear the counter, increment the bit counter.
  - After the DBIT-th bit, go to PARITY if parity is compiled in, otherwise to STOP.
- PARITY: at bit centre, capture the parity bit and go to STOP.
- STOP: at bit centre:
  - frame_err_next = ~rx_s.
  - Complete the byte and go to IDLE. IDLE is entered at mid stop bit, so back-to-back frames are accepted.
- Completion with the holding register empty, or drained in the same cycle (rx_valid & rx_ready): load rx_data, frame_err and parity_err, and set rx_valid to 1. No overrun in this case.
- Completion while rx_valid=1 and rx_ready=0: drop the new byte, keep the held byte and its flags, and set overrun.
- A handshake with no completion in the same cycle clears rx_valid and overrun. Data and flag outputs keep their values.
- A byte is delivered even if it has a framing error; frame_err marks it.

## Timing
- All outputs reset to 0: rx_data, rx_valid, frame_err, parity_err, overrun.
- Asserting reset_n mid-frame aborts immediately to IDLE and discards the partial byte. The synchronizer goes to 1.
- Start detection: 2 clk after the rx falling edge, plus 1 clk to enter START.
- rx_valid rises on the clk edge of the s_tick that ends STOP. That is OVS/2 + (DBIT+1)*OVS ticks after entering START, or OVS/2 + (DBIT+2)*OVS ticks with parity. For 8N1 at OVS=16 this is 152 ticks.
- rx_valid is registered and has no combinational path from rx_ready.
- rx_valid drops on the clk edge after the handshake, unless a byte completes in the same cycle.

## Configuration
- Macro: UART_RX_PARITY_EN.
- Defined:
  - The PARITY state is present and the frame is start + DBIT + parity + stop.
  - parity_err = (^data ^ parity_bit) != PARITY_ODD.
- Undefined:
  - The PARITY state and its logic are removed and the frame is start + DBIT + stop.
  - The parity_err port still exists and is tied to 0.

## Test plan
- Reset: hold reset_n low with rx toggling -> all outputs 0. After release, rx idle high -> no rx_valid for 1000 ticks.
- 8N1, s_tick every 4 clk, send 0xA5 -> rx_data=0xA5, rx_valid=1, frame_err=0, 152 ticks after START. Pulse rx_ready -> rx_valid=0.
- Glitch: rx low for 4 ticks then high -> no byte, FSM back in IDLE. A following 0x3C frame -> rx_data=0x3C.
- Framing: send 0xFF with the stop bit driven 0 -> rx_valid=1, rx_data=0xFF, frame_err=1.
- Overrun: rx_ready=0, send 0x11 then 0x22 back-to-back -> rx_data=0x11, overrun=1. Assert rx_ready for 1 clk -> rx_valid=0, overrun=0. Also cover completion coinciding with the handshake -> new byte held, overrun stays 0.
- UART_RX_PARITY_EN with PARITY_ODD=0: 0x07 with parity bit 1 -> parity_err=0. 0x07 with parity bit 0 -> parity_err=1. Pull reset_n low mid-DATA -> outputs 0 and the next frame is received cleanly.
